// File: rtl/encoder_m_to_n_seq.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_m_to_n_seq
//  Description : Sequential priority encoder. Captures request bits into a
//                pending register and emits their indices lowest-first, one
//                per valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder_m_to_n_seq #(
    parameter int NUMBER_OF_INPUT  = 8,
    parameter int NUMBER_OF_OUTPUT = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [NUMBER_OF_INPUT-1:0]  x,
    input  logic                        ready,
    output logic [NUMBER_OF_OUTPUT-1:0] y,
    output logic                        valid,
    output logic [NUMBER_OF_INPUT-1:0]  pending,
    output logic                        busy
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_HOLD = 1'b1;

    logic [0:0]                  r_state;
    logic [NUMBER_OF_OUTPUT-1:0] r_y;
    logic                        r_valid;
    logic [NUMBER_OF_INPUT-1:0]  r_pending;

    logic [NUMBER_OF_OUTPUT-1:0] w_sel;
    logic [NUMBER_OF_INPUT-1:0]  w_sel_onehot;
    logic                        w_any;
    logic                        w_load;
    logic [NUMBER_OF_INPUT-1:0]  w_served;
    logic [NUMBER_OF_INPUT-1:0]  w_capture;
    logic [NUMBER_OF_INPUT-1:0]  w_pending_next;

    // Descending scan: the last hit, i.e. the lowest set index, wins.
    always_comb begin
        w_sel        = '0;
        w_sel_onehot = '0;
        for (int i = NUMBER_OF_INPUT - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel           = NUMBER_OF_OUTPUT'(i);
                w_sel_onehot    = '0;
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    assign w_any          = |r_pending;
    assign w_load         = w_any && ((r_state == c_IDLE) || ready);
    assign w_served       = w_load ? w_sel_onehot : '0;
    assign w_capture      = enable ? x : '0;
    // Capture is OR-ed in after the clear so a re-asserted served bit survives.
    assign w_pending_next = (r_pending & ~w_served) | w_capture;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_y       <= '0;
            r_valid   <= 1'b0;
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_y     <= w_sel;
                        r_valid <= 1'b1;
                        r_state <= c_HOLD;
                    end
                end
                c_HOLD: begin
                    if (ready) begin
                        if (w_any) begin
                            r_y <= w_sel;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= c_IDLE;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign y       = r_y;
    assign valid   = r_valid;
    assign pending = r_pending;
    assign busy    = r_valid | (|r_pending);

endmodule
`default_nettype wire

// File: tb/tb_encoder_m_to_n_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder_m_to_n_seq
//  Description : Bench for encoder_m_to_n_seq: directed scenarios plus random
//                traffic against a request-set reference model and scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_m_to_n_seq;

    localparam int M = 8;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [M-1:0] x = '0;
    logic         ready = 1'b0;
    logic [N-1:0] y;
    logic         valid;
    logic [M-1:0] pending;
    logic         busy;

    encoder_m_to_n_seq #(
        .NUMBER_OF_INPUT (M),
        .NUMBER_OF_OUTPUT(N)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .x      (x),
        .ready  (ready),
        .y      (y),
        .valid  (valid),
        .pending(pending),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    // Reference model: a set of outstanding request indices plus the code on offer.
    bit req_set[M];
    bit m_valid = 1'b0;
    int m_y     = 0;

    function automatic int set_as_int();
        int v = 0;
        for (int i = 0; i < M; i++) if (req_set[i]) v += (1 << i);
        return v;
    endfunction

    function automatic int lowest_request();
        for (int i = 0; i < M; i++) if (req_set[i]) return i;
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int low;
        if (!rst_n) begin
            for (int i = 0; i < M; i++) req_set[i] = 1'b0;
            m_valid = 1'b0;
            m_y     = 0;
            exp_q.delete();
        end else begin
            low = lowest_request();
            if (low >= 0 && (!m_valid || ready)) begin
                m_y          = low;
                m_valid      = 1'b1;
                req_set[low] = 1'b0;
                exp_q.push_back(low);
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
            if (enable) for (int i = 0; i < M; i++) if (x[i]) req_set[i] = 1'b1;
        end
    endtask

    task automatic step(input bit r, input bit en, input logic [M-1:0] xv, input bit rd);
        rst_n  = r;
        enable = en;
        x      = xv;
        ready  = rd;
        @(posedge clk);
        model_edge();
        #1;
        check("valid", int'(valid), int'(m_valid));
        check("pending", int'(pending), set_as_int());
        check("busy", int'(busy), int'(m_valid || set_as_int() != 0));
        check("y", int'(y), m_y);
    endtask

    // Monitor: every accepted code must be the oldest one the model put on offer.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got code %0d, expected no handshake", y);
            end else begin
                check("sb_code", int'(y), exp_q.pop_front());
            end
        end
    end

    initial begin
        int guard;
        for (int i = 0; i < M; i++) req_set[i] = 1'b0;

        // Reset with requests driven, then release with x=0.
        step(0, 1, 8'hFF, 0);
        step(0, 1, 8'hFF, 0);
        step(1, 0, 8'h00, 0);
        check("t1_valid", int'(valid), 0);
        check("t1_y", int'(y), 0);
        check("t1_pending", int'(pending), 0);
        check("t1_busy", int'(busy), 0);

        // Single request: one edge to capture, one edge to present.
        step(1, 1, 8'b0000_0100, 1);
        check("t2_capture_valid", int'(valid), 0);
        step(1, 0, 8'h00, 1);
        check("t2_valid", int'(valid), 1);
        check("t2_y", int'(y), 2);
        check("t2_pending", int'(pending), 0);
        step(1, 0, 8'h00, 1);
        check("t2_done", int'(valid), 0);

        // Backpressure holds y stable.
        step(1, 1, 8'b1000_0001, 0);
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 8'h00, 0);
            check("t3_hold_y", int'(y), 0);
            check("t3_hold_valid", int'(valid), 1);
            check("t3_hold_pending", int'(pending), 8'h80);
        end
        step(1, 0, 8'h00, 1);
        check("t3_next_y", int'(y), 7);
        step(1, 0, 8'h00, 1);
        check("t3_done", int'(valid), 0);

        // enable gating, then a full burst with no bubbles.
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 8'hFF, 1);
            check("t4_gated_valid", int'(valid), 0);
            check("t4_gated_pending", int'(pending), 0);
        end
        step(1, 1, 8'hFF, 1);
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 8'h00, 1);
            check("t4_burst_valid", int'(valid), 1);
            check("t4_burst_y", int'(y), k);
        end
        step(1, 0, 8'h00, 1);
        check("t4_done", int'(valid), 0);

        // Set wins over the served bit.
        step(1, 1, 8'b0000_1000, 1);
        step(1, 0, 8'h00, 1);
        check("t5_first_y", int'(y), 3);
        step(1, 1, 8'b0000_1000, 1);
        check("t5_repending", int'(pending), 8'h08);
        step(1, 0, 8'h00, 1);
        check("t5_again_valid", int'(valid), 1);
        check("t5_again_y", int'(y), 3);
        step(1, 0, 8'h00, 1);

        // Reset mid-HOLD drops the offered code and the pending requests.
        step(1, 1, 8'hE0, 0);
        step(1, 0, 8'h00, 0);
        check("t6_pre_y", int'(y), 5);
        check("t6_pre_pending", int'(pending), 8'hC0);
        step(0, 0, 8'h00, 0);
        check("t6_rst_valid", int'(valid), 0);
        check("t6_rst_y", int'(y), 0);
        check("t6_rst_pending", int'(pending), 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 8'h00, 1);
            check("t6_quiet", int'(valid), 0);
        end

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            logic [M-1:0] xr;
            xr = M'($urandom) & M'($urandom);
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0), xr,
                 ($urandom_range(0, 3) != 0));
        end

        // Drain, bounded.
        guard = 0;
        while ((m_valid || set_as_int() != 0) && guard < 40) begin
            step(1, 0, 8'h00, 1);
            guard++;
        end
        check("drain_in_budget", int'(m_valid || set_as_int() != 0), 0);
        step(1, 0, 8'h00, 1);
        check("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
